// File: rtl/axi4_bridge_pkg.sv
// Shared AXI4 constants and FSM state encodings for the single-beat AXI4 bridge.
package axi4_bridge_pkg;

    localparam logic [7:0] LEN_SINGLE  = 8'd0;
    localparam logic [2:0] SIZE_8B     = 3'b011;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_AR,
        RD_R,
        RD_DONE
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_AW,
        WR_B,
        WR_DONE
    } wr_state_t;

endpackage

// File: rtl/axi4_bridge_wr.sv
// Write-side FSM of the AXI4 bridge: issues AW and W together, retires each
// channel independently, then waits for the B response.
module axi4_bridge_wr
    import axi4_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_data,
    input  logic [DATA_W/8-1:0] req_mask,
    output logic                done,
    output logic                err,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp
);

    wr_state_t state_q;
    wr_state_t state_d;
    logic      aw_done_q;
    logic      w_done_q;
    logic [1:0] resp_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Each flag remembers that its channel handshook, so its valid stays low
    // while the other channel is still waiting; both clear on leaving WR_AW.
    always_ff @(posedge clk) begin
        if (!rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            aw_done_q <= (state_q == WR_AW) && (state_d == WR_AW) && (aw_done_q || awready);
            w_done_q  <= (state_q == WR_AW) && (state_d == WR_AW) && (w_done_q || wready);
            if (state_q == WR_IDLE && req) begin
                awaddr <= req_addr;
                wdata  <= req_data;
                wstrb  <= req_mask;
            end
            if (state_q == WR_B && bvalid) begin
                resp_q <= bresp;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            WR_IDLE: begin
                if (req) begin
                    state_d = WR_AW;
                end
            end
            WR_AW: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if ((aw_done_q || awready) && (w_done_q || wready)) begin
                    state_d = WR_B;
                end
            end
            WR_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_d = WR_DONE;
                end
            end
            WR_DONE: begin
                done    = 1'b1;
                err     = (resp_q != RESP_OKAY);
                state_d = WR_IDLE;
            end
            default: state_d = WR_IDLE;
        endcase
    end

endmodule

// File: rtl/axi4_bridge.sv
// Converts single-beat arbiter read/write requests into AXI4 master
// transactions; one outstanding transaction per direction.
module axi4_bridge
    import axi4_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ar_e_i,
    input  logic                ar_id_i,
    input  logic [ADDR_W-1:0]   ar_addr_i,
    output logic [DATA_W-1:0]   r_data_o,
    output logic                r_id_o,
    output logic                r_over_o,
    output logic                r_err_o,
    input  logic                aw_e_i,
    input  logic [ADDR_W-1:0]   aw_addr_i,
    input  logic [DATA_W-1:0]   w_data_i,
    input  logic [DATA_W/8-1:0] w_mask_i,
    output logic                w_over_o,
    output logic                w_err_o,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [ID_W-1:0]     arid,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [ID_W-1:0]     rid,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [ID_W-1:0]     awid,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp
);

    rd_state_t         rd_state_q;
    rd_state_t         rd_state_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_id_q;
    logic [1:0]        rd_resp_q;

    // With a single outstanding transaction per direction, response ids carry no information.
    logic unused_ids;
    assign unused_ids = ^{rid, bid};

    assign arlen   = LEN_SINGLE;
    assign arsize  = SIZE_8B;
    assign arburst = BURST_INCR;
    assign awlen   = LEN_SINGLE;
    assign awsize  = SIZE_8B;
    assign awburst = BURST_INCR;
    assign awid    = '0;
    assign wlast   = 1'b1;
    assign araddr  = rd_addr_q;
    assign arid    = ID_W'(rd_id_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_state_q <= RD_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    // Only the rlast beat completes a read; stray non-last beats are accepted and dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_addr_q <= '0;
            rd_id_q   <= 1'b0;
            rd_resp_q <= RESP_OKAY;
            r_data_o  <= '0;
            r_id_o    <= 1'b0;
        end else begin
            if (rd_state_q == RD_IDLE && ar_e_i) begin
                rd_addr_q <= ar_addr_i;
                rd_id_q   <= ar_id_i;
            end
            if (rd_state_q == RD_R && rvalid && rlast) begin
                r_data_o  <= rdata;
                rd_resp_q <= rresp;
                r_id_o    <= rd_id_q;
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arvalid    = 1'b0;
        rready     = 1'b0;
        r_over_o   = 1'b0;
        r_err_o    = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_e_i) begin
                    rd_state_d = RD_AR;
                end
            end
            RD_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    rd_state_d = RD_R;
                end
            end
            RD_R: begin
                rready = 1'b1;
                if (rvalid && rlast) begin
                    rd_state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                r_over_o   = 1'b1;
                r_err_o    = (rd_resp_q != RESP_OKAY);
                rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    axi4_bridge_wr #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_wr (
        .clk     (clk),
        .rst     (rst),
        .req     (aw_e_i),
        .req_addr(aw_addr_i),
        .req_data(w_data_i),
        .req_mask(w_mask_i),
        .done    (w_over_o),
        .err     (w_err_o),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp)
    );

endmodule

// File: tb/tb_axi4_bridge.sv
// Directed, table-driven bench for axi4_bridge with a cycle-stepped AXI4 slave model.
module tb_axi4_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_e_i;
    logic        ar_id_i;
    logic [31:0] ar_addr_i;
    logic [63:0] r_data_o;
    logic        r_id_o;
    logic        r_over_o;
    logic        r_err_o;
    logic        aw_e_i;
    logic [31:0] aw_addr_i;
    logic [63:0] w_data_i;
    logic [7:0]  w_mask_i;
    logic        w_over_o;
    logic        w_err_o;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic        wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic        id;
        logic [63:0] data;
        logic [7:0]  mask;
        int          a_dly;
        int          w_dly;
        int          resp_dly;
        logic [1:0]  resp;
        bit          junk;
        int          exp_cycle;
        bit          exp_err;
        int          exp_a_cycles;
        int          exp_w_cycles;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    axi4_bridge dut (
        .clk(clk), .rst(rst),
        .ar_e_i(ar_e_i), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
        .r_data_o(r_data_o), .r_id_o(r_id_o), .r_over_o(r_over_o), .r_err_o(r_err_o),
        .aw_e_i(aw_e_i), .aw_addr_i(aw_addr_i), .w_data_i(w_data_i), .w_mask_i(w_mask_i),
        .w_over_o(w_over_o), .w_err_o(w_err_o),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Read transaction: cycle 0 raises ar_e_i; the slave answers after the vector's delays.
    task automatic runRead(input vec_t v, input string tag);
        int  c = 0;
        int  ar_wait = 0;
        int  r_wait = 0;
        int  first_av = -1;
        int  done_c = -1;
        int  pulses = 0;
        int  a_cycles = 0;
        bit  addr_bad = 1'b0;
        bit  err_seen = 1'b0;
        logic [63:0] data_seen = '0;
        logic        id_seen = 1'b0;
        ar_addr_i = v.addr;
        ar_id_i   = v.id;
        ar_e_i    = 1'b1;
        while (c < 60 && !(done_c >= 0 && c >= done_c + 2)) begin
            tick();
            c++;
            arready = 1'b0;
            rvalid  = 1'b0;
            rlast   = 1'b0;
            rdata   = '0;
            rresp   = 2'b00;
            if (arvalid) begin
                if (first_av < 0) first_av = c;
                a_cycles++;
                if (araddr !== v.addr || arid !== {3'b000, v.id} || arlen !== 8'd0 ||
                    arsize !== 3'b011 || arburst !== 2'b01) addr_bad = 1'b1;
                arready = (ar_wait >= v.a_dly);
                ar_wait++;
            end
            if (rready) begin
                if (r_wait >= v.resp_dly) begin
                    rvalid = 1'b1;
                    rlast  = 1'b1;
                    rdata  = v.data;
                    rresp  = v.resp;
                end else if (v.junk) begin
                    rvalid = 1'b1;
                    rdata  = ~v.data;
                    rresp  = 2'b10;
                end
                r_wait++;
            end
            if (r_over_o) begin
                pulses++;
                if (done_c < 0) begin
                    done_c    = c;
                    data_seen = r_data_o;
                    err_seen  = r_err_o;
                    id_seen   = r_id_o;
                end
                ar_e_i = 1'b0;
            end
        end
        ar_e_i = 1'b0;
        checkOutput({tag, " rd_done_cycle"}, done_c, v.exp_cycle);
        checkOutput({tag, " rd_pulses"}, pulses, 1);
        checkOutput({tag, " rd_data"}, data_seen, v.data);
        checkOutput({tag, " rd_err"}, err_seen, v.exp_err);
        checkOutput({tag, " rd_id"}, id_seen, v.id);
        checkOutput({tag, " arvalid_rise"}, first_av, 1);
        checkOutput({tag, " arvalid_cycles"}, a_cycles, v.exp_a_cycles);
        checkOutput({tag, " ar_stable"}, addr_bad, 0);
        checkOutput({tag, " rd_data_held"}, r_data_o, v.data);
    endtask

    // Write transaction: AW and W accepted after independent delays, then B after resp_dly.
    task automatic runWrite(input vec_t v, input string tag);
        int c = 0;
        int aw_wait = 0;
        int w_wait = 0;
        int b_wait = 0;
        int first_aw = -1;
        int first_w = -1;
        int done_c = -1;
        int pulses = 0;
        int a_cycles = 0;
        int w_cycles = 0;
        bit bad = 1'b0;
        bit err_seen = 1'b0;
        aw_addr_i = v.addr;
        w_data_i  = v.data;
        w_mask_i  = v.mask;
        aw_e_i    = 1'b1;
        while (c < 60 && !(done_c >= 0 && c >= done_c + 2)) begin
            tick();
            c++;
            awready = 1'b0;
            wready  = 1'b0;
            bvalid  = 1'b0;
            bresp   = 2'b00;
            if (awvalid) begin
                if (first_aw < 0) first_aw = c;
                a_cycles++;
                if (awaddr !== v.addr || awid !== 4'd0 || awlen !== 8'd0 ||
                    awsize !== 3'b011 || awburst !== 2'b01) bad = 1'b1;
                awready = (aw_wait >= v.a_dly);
                aw_wait++;
            end
            if (wvalid) begin
                if (first_w < 0) first_w = c;
                w_cycles++;
                if (wdata !== v.data || wstrb !== v.mask || wlast !== 1'b1) bad = 1'b1;
                wready = (w_wait >= v.w_dly);
                w_wait++;
            end
            if (bready) begin
                if (b_wait >= v.resp_dly) begin
                    bvalid = 1'b1;
                    bresp  = v.resp;
                end
                b_wait++;
            end
            if (w_over_o) begin
                pulses++;
                if (done_c < 0) begin
                    done_c   = c;
                    err_seen = w_err_o;
                end
                aw_e_i = 1'b0;
            end
        end
        aw_e_i = 1'b0;
        checkOutput({tag, " wr_done_cycle"}, done_c, v.exp_cycle);
        checkOutput({tag, " wr_pulses"}, pulses, 1);
        checkOutput({tag, " wr_err"}, err_seen, v.exp_err);
        checkOutput({tag, " awvalid_rise"}, first_aw, 1);
        checkOutput({tag, " wvalid_rise"}, first_w, 1);
        checkOutput({tag, " awvalid_cycles"}, a_cycles, v.exp_a_cycles);
        checkOutput({tag, " wvalid_cycles"}, w_cycles, v.exp_w_cycles);
        checkOutput({tag, " aw_w_payload"}, bad, 0);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        if (v.is_wr) runWrite(v, tag);
        else         runRead(v, tag);
    endtask

    initial begin
        // is_wr addr id data mask a_dly w_dly resp_dly resp junk | exp_cycle exp_err exp_a exp_w
        tbl[0] = '{0, 32'h8000_0000, 1'b1, 64'h1122_3344_5566_7788, 8'h00, 0, 0, 0, 2'b00, 0, 3, 0, 1, 0};
        tbl[1] = '{0, 32'h8000_0040, 1'b0, 64'hCAFE_F00D_1234_5678, 8'h00, 4, 0, 3, 2'b00, 0, 10, 0, 5, 0};
        tbl[2] = '{0, 32'h9000_0008, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'h00, 1, 0, 0, 2'b11, 0, 4, 1, 2, 0};
        tbl[3] = '{0, 32'h8000_1000, 1'b0, 64'h0123_4567_89AB_CDEF, 8'h00, 0, 0, 2, 2'b00, 1, 5, 0, 1, 0};
        tbl[4] = '{1, 32'hA000_0000, 1'b0, 64'h55AA_55AA_0F0F_F0F0, 8'h0F, 4, 2, 0, 2'b00, 0, 7, 0, 5, 3};
        tbl[5] = '{1, 32'hB000_0010, 1'b0, 64'hFFFF_0000_FFFF_0000, 8'hFF, 0, 0, 0, 2'b00, 0, 3, 0, 1, 1};
        tbl[6] = '{1, 32'hB000_0020, 1'b0, 64'h0000_0000_0000_00A5, 8'h01, 1, 3, 2, 2'b10, 0, 8, 1, 2, 4};
        tbl[7] = '{1, 32'hC000_0008, 1'b0, 64'h8765_4321_8765_4321, 8'hA5, 0, 2, 1, 2'b00, 0, 6, 0, 1, 3};

        rst = 1'b0;
        ar_e_i = 1'b0; ar_id_i = 1'b0; ar_addr_i = '0;
        aw_e_i = 1'b0; aw_addr_i = '0; w_data_i = '0; w_mask_i = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rid = '0; rresp = '0; rlast = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        tick();
        tick();
        checkOutput("rst arvalid", arvalid, 0);
        checkOutput("rst rready", rready, 0);
        checkOutput("rst awvalid", awvalid, 0);
        checkOutput("rst wvalid", wvalid, 0);
        checkOutput("rst bready", bready, 0);
        checkOutput("rst r_over", r_over_o, 0);
        checkOutput("rst w_over", w_over_o, 0);
        checkOutput("rst r_err", r_err_o, 0);
        checkOutput("rst w_err", w_err_o, 0);
        checkOutput("rst r_id", r_id_o, 0);
        checkOutput("rst r_data", r_data_o, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i], $sformatf("vec%0d", i));
        end

        // Both directions requested in the same cycle, no handshake stalls.
        fork
            runRead(tbl[0], "simul");
            runWrite(tbl[5], "simul");
        join

        // Reset while the read FSM waits in RD_R for data that never comes.
        ar_addr_i = 32'h8000_2000;
        ar_id_i   = 1'b1;
        ar_e_i    = 1'b1;
        tick();
        checkOutput("midrst arvalid_up", arvalid, 1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checkOutput("midrst rready_up", rready, 1);
        rst    = 1'b0;
        ar_e_i = 1'b0;
        tick();
        checkOutput("midrst arvalid", arvalid, 0);
        checkOutput("midrst rready", rready, 0);
        checkOutput("midrst r_over", r_over_o, 0);
        checkOutput("midrst r_data", r_data_o, 0);
        checkOutput("midrst r_id", r_id_o, 0);
        rst = 1'b1;
        tick();
        applyStimulus(tbl[0], "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
